// File: rtl/clock_time_ctrl.sv
// Sequencing controller for the hour/minute/second counter chain: 1 Hz prescaler,
// pause mode and field-set mode driven by debounced push buttons.
module clock_time_ctrl #(
    parameter int TICK_DIV  = 50000000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic       clk,
    input  logic       glob_rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_pause,
    input  logic       carry_sec_in,
    input  logic       carry_min_in,
    output logic       ce_sec,
    output logic       ce_min,
    output logic       ce_hr,
    output logic [2:0] mode,
    output logic       blink
);

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        PAUSE   = 3'd1,
        SET_HR  = 3'd2,
        SET_MIN = 3'd3,
        SET_SEC = 3'd4
    } state_t;

    localparam int PW = $clog2(TICK_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST  = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    state_t        state, state_next;
    logic [PW-1:0] prescaler;
    logic [BW-1:0] blink_cnt;
    logic          btn_mode_q, btn_inc_q, btn_pause_q;
    logic          press_mode, press_inc, press_pause;
    logic          tick;
    logic          ce_sec_next, ce_min_next, ce_hr_next;
    logic          set_next, entering_set;

    assign press_mode  = btn_mode  & ~btn_mode_q;
    assign press_inc   = btn_inc   & ~btn_inc_q;
    assign press_pause = btn_pause & ~btn_pause_q;

    assign tick         = (state == RUN) && (prescaler == TICK_LAST);
    assign set_next     = (state_next == SET_HR) || (state_next == SET_MIN) ||
                          (state_next == SET_SEC);
    assign entering_set = set_next && (state_next != state);

    assign mode = state;

    // NOTE: every signal assigned here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_next  = state;
        ce_sec_next = 1'b0;
        ce_min_next = 1'b0;
        ce_hr_next  = 1'b0;
        unique case (state)
            RUN: begin
                if (press_mode)       state_next = SET_HR;
                else if (press_pause) state_next = PAUSE;
                ce_sec_next = tick;
                ce_min_next = tick & carry_sec_in;
                ce_hr_next  = tick & carry_sec_in & carry_min_in;
            end
            PAUSE: begin
                if (press_mode)       state_next = SET_HR;
                else if (press_pause) state_next = RUN;
            end
            // Increments in set states hit the current field only; the counter wraps itself.
            SET_HR: begin
                if (press_mode) state_next = SET_MIN;
                ce_hr_next = press_inc;
            end
            SET_MIN: begin
                if (press_mode) state_next = SET_SEC;
                ce_min_next = press_inc;
            end
            SET_SEC: begin
                if (press_mode) state_next = RUN;
                ce_sec_next = press_inc;
            end
            default: state_next = RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (glob_rst) begin
            state       <= RUN;
            prescaler   <= '0;
            blink_cnt   <= '0;
            blink       <= 1'b0;
            ce_sec      <= 1'b0;
            ce_min      <= 1'b0;
            ce_hr       <= 1'b0;
            // History starts high so a button held through reset is not a press.
            btn_mode_q  <= 1'b1;
            btn_inc_q   <= 1'b1;
            btn_pause_q <= 1'b1;
        end else begin
            state       <= state_next;
            ce_sec      <= ce_sec_next;
            ce_min      <= ce_min_next;
            ce_hr       <= ce_hr_next;
            btn_mode_q  <= btn_mode;
            btn_inc_q   <= btn_inc;
            btn_pause_q <= btn_pause;

            if (state != RUN || tick) prescaler <= '0;
            else                      prescaler <= prescaler + PW'(1);

            if (!set_next) begin
                blink     <= 1'b0;
                blink_cnt <= '0;
            end else if (entering_set) begin
                blink     <= 1'b1;
                blink_cnt <= '0;
            end else if (blink_cnt == BLINK_LAST) begin
                blink     <= ~blink;
                blink_cnt <= '0;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Directed testbench for clock_time_ctrl with small dividers (tick 4, blink 3).
module tb_clock_time_ctrl;

    localparam int TICK_DIV  = 4;
    localparam int BLINK_DIV = 3;

    logic       clk;
    logic       glob_rst;
    logic       btn_mode, btn_inc, btn_pause;
    logic       carry_sec_in, carry_min_in;
    logic       ce_sec, ce_min, ce_hr;
    logic [2:0] mode;
    logic       blink;

    int checks   = 0;
    int failures = 0;
    int tb_pre;

    clock_time_ctrl #(
        .TICK_DIV (TICK_DIV),
        .BLINK_DIV(BLINK_DIV)
    ) dut (
        .clk         (clk),
        .glob_rst    (glob_rst),
        .btn_mode    (btn_mode),
        .btn_inc     (btn_inc),
        .btn_pause   (btn_pause),
        .carry_sec_in(carry_sec_in),
        .carry_min_in(carry_min_in),
        .ce_sec      (ce_sec),
        .ce_min      (ce_min),
        .ce_hr       (ce_hr),
        .mode        (mode),
        .blink       (blink)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] obs();
        return {mode, ce_hr, ce_min, ce_sec, blink};
    endfunction

    function automatic logic [6:0] pack(input logic [2:0] m, input logic h, input logic mi,
                                        input logic s, input logic b);
        return {m, h, mi, s, b};
    endfunction

    task automatic test_reset();
        logic [6:0] e;
        glob_rst = 1'b1;
        btn_mode = 1'b1;
        btn_inc = 1'b0;
        btn_pause = 1'b0;
        carry_sec_in = 1'b0;
        carry_min_in = 1'b0;
        repeat (2) step();
        e = pack(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs() !== e) begin
            failures++;
            $display("FAIL reset_state got=%b exp=%b", obs(), e);
        end
        glob_rst = 1'b0;
        tb_pre = 0;
    endtask

    task automatic run_phase(input string name, input int n, input logic csec, input logic cmin);
        logic [6:0] e;
        logic s;
        carry_sec_in = csec;
        carry_min_in = cmin;
        for (int k = 1; k <= n; k++) begin
            step();
            s = (tb_pre == TICK_DIV - 1);
            tb_pre = (tb_pre + 1) % TICK_DIV;
            e = pack(3'd0, s & csec & cmin, s & csec, s, 1'b0);
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL %s k=%0d got=%b exp=%b", name, k, obs(), e);
            end
            btn_mode = 1'b0;
        end
    endtask

    task automatic test_run_carries();
        run_phase("run_tick", 12, 1'b0, 1'b0);
        run_phase("run_carry_sec", 8, 1'b1, 1'b0);
        run_phase("run_carry_both", 8, 1'b1, 1'b1);
    endtask

    task automatic test_pause();
        logic [6:0] e;
        logic s;
        btn_pause = 1'b1;
        step();
        e = pack(3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs() !== e) begin
            failures++;
            $display("FAIL enter_pause got=%b exp=%b", obs(), e);
        end
        btn_pause = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL pause_hold k=%0d got=%b exp=%b", k, obs(), e);
            end
            btn_inc = (k == 9);
        end
        btn_pause = 1'b1;
        step();
        e = pack(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs() !== e) begin
            failures++;
            $display("FAIL resume got=%b exp=%b", obs(), e);
        end
        btn_pause = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            s = (k == 4);
            e = pack(3'd0, s, s, s, 1'b0);
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL resume_tick k=%0d got=%b exp=%b", k, obs(), e);
            end
        end
        tb_pre = 0;
    endtask

    task automatic test_set_hr();
        logic [6:0] e;
        logic b;
        btn_mode = 1'b1;
        step();
        e = pack(3'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (obs() !== e) begin
            failures++;
            $display("FAIL enter_set_hr got=%b exp=%b", obs(), e);
        end
        btn_mode = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            if (k == 10) btn_inc = 1'b1;
            if (k == 15) btn_inc = 1'b0;
            step();
            b = ((k / BLINK_DIV) % 2 == 0);
            e = pack(3'd2, k == 10, 1'b0, 1'b0, b);
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL set_hr k=%0d got=%b exp=%b", k, obs(), e);
            end
        end
    endtask

    task automatic check_mode_ce(input string name, input logic [6:0] e);
        logic [6:0] got;
        got = obs();
        checks++;
        if (got[6:1] !== e[6:1]) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", name, got[6:1], e[6:1]);
        end
    endtask

    task automatic test_set_sequence();
        logic [6:0] e;
        logic s;
        btn_mode = 1'b1;
        step();
        e = pack(3'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (obs() !== e) begin
            failures++;
            $display("FAIL enter_set_min got=%b exp=%b", obs(), e);
        end
        btn_mode = 1'b0;
        btn_pause = 1'b1;
        step();
        check_mode_ce("pause_ignored_set", pack(3'd3, 1'b0, 1'b0, 1'b0, 1'b0));
        btn_pause = 1'b0;
        btn_inc = 1'b1;
        step();
        check_mode_ce("inc_set_min", pack(3'd3, 1'b0, 1'b1, 1'b0, 1'b0));
        btn_inc = 1'b0;
        step();
        btn_mode = 1'b1;
        btn_inc = 1'b1;
        step();
        e = pack(3'd4, 1'b0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (obs() !== e) begin
            failures++;
            $display("FAIL inc_with_mode got=%b exp=%b", obs(), e);
        end
        btn_mode = 1'b0;
        btn_inc = 1'b0;
        step();
        check_mode_ce("set_sec_idle", pack(3'd4, 1'b0, 1'b0, 1'b0, 1'b0));
        btn_inc = 1'b1;
        step();
        check_mode_ce("inc_set_sec", pack(3'd4, 1'b0, 1'b0, 1'b1, 1'b0));
        btn_inc = 1'b0;
        step();
        btn_mode = 1'b1;
        step();
        e = pack(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs() !== e) begin
            failures++;
            $display("FAIL exit_to_run got=%b exp=%b", obs(), e);
        end
        btn_mode = 1'b0;
        carry_sec_in = 1'b0;
        carry_min_in = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            s = (k == 4);
            e = pack(3'd0, 1'b0, 1'b0, s, 1'b0);
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL run_restart k=%0d got=%b exp=%b", k, obs(), e);
            end
        end
        btn_mode = 1'b1;
        btn_pause = 1'b1;
        step();
        e = pack(3'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (obs() !== e) begin
            failures++;
            $display("FAIL mode_beats_pause got=%b exp=%b", obs(), e);
        end
        btn_mode = 1'b0;
        btn_pause = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        logic [6:0] e;
        btn_mode = 1'b1;
        step();
        check_mode_ce("to_set_min", pack(3'd3, 1'b0, 1'b0, 1'b0, 1'b0));
        btn_mode = 1'b0;
        carry_sec_in = 1'b1;
        carry_min_in = 1'b1;
        step();
        glob_rst = 1'b1;
        btn_inc = 1'b1;
        step();
        e = pack(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs() !== e) begin
            failures++;
            $display("FAIL reset_in_set got=%b exp=%b", obs(), e);
        end
        glob_rst = 1'b0;
        tb_pre = 0;
        run_phase("after_reset_held_inc", 11, 1'b0, 1'b0);
        glob_rst = 1'b1;
        carry_sec_in = 1'b1;
        step();
        checks++;
        if (obs() !== e) begin
            failures++;
            $display("FAIL reset_on_wrap got=%b exp=%b", obs(), e);
        end
        glob_rst = 1'b0;
        btn_inc = 1'b0;
        carry_sec_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_run_carries();
        test_pause();
        test_set_hr();
        test_set_sequence();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
